nmr_vote_monitor: RTL

Parametrised N-modular-redundancy vote-and-monitor stage for the redundant RISC-V core cluster. It replaces the fixed three-core voter path with a word-level majority vote over `LANES` core outputs. It tracks per-lane consecutive mismatches and masks a lane out of the vote once it is declared failed. It also requests re-synchronisation of failed lanes from the PC/recovery controller through a req/ack handshake. It sits between the `Main_core` instances and the data-memory/recovery-register path.

---
 rtl/nmr_vote_monitor.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/nmr_vote_monitor.sv
// -----------------------------------------------------------------------------
// nmr_vote_monitor
//
// Word-level N-modular-redundancy voter with per-lane health monitoring.
// Each cycle with valid_in=1 the LANES lane words are compared. Only lanes
// not marked failed take part. The lowest-index enabled lane whose word is
// shared by a strict majority of enabled lanes wins. Lanes that disagree with
// the winner build up a consecutive-mismatch count. When that count reaches
// THRESH, the lane is masked out of later votes.
//
// Optional feature, selected by the macro NMR_AUTO_RECOVER_EN:
//   defined     : a two-state recovery FSM requests re-synchronisation of the
//                 lowest failed lane via recover_req/recover_lane. On
//                 recover_ack it clears that lane's failed flag and counter.
//   not defined : lane_failed is sticky until rst_in. recover_req and
//                 recover_lane are tied to 0 and recover_ack is ignored.
//
// Parameters
//   WIDTH   payload width per lane
//   LANES   number of redundant lanes (odd, 3..7)
//   THRESH  consecutive mismatches that declare a lane failed (1..15)
//   LW      lane index width
//
// Ports
//   clk           in   clock, all state on rising edge
//   rst_in        in   synchronous active-high reset
//   valid_in      in   lane_data valid this cycle
//   lane_data     in   LANES*WIDTH, lane i at [i*WIDTH +: WIDTH]
//   voted_data    out  registered majority word (holds when no majority)
//   voted_valid   out  majority found for the accepted input
//   no_majority   out  input accepted but no majority among enabled lanes
//   lane_err      out  per-lane disagreement with the winner on last vote
//   lane_failed   out  sticky failed-lane mask
//   recover_req   out  recovery request
//   recover_lane  out  lane being recovered, stable while recover_req=1
//   recover_ack   in   recovery of recover_lane complete
//   fault_count   out  saturating count of votes with any lane_err set
// -----------------------------------------------------------------------------
module nmr_vote_monitor #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 3,
  parameter int THRESH = 4,
  parameter int LW     = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [LANES*WIDTH-1:0] lane_data,
  output logic [WIDTH-1:0]       voted_data,
  output logic                   voted_valid,
  output logic                   no_majority,
  output logic [LANES-1:0]       lane_err,
  output logic [LANES-1:0]       lane_failed,
  output logic                   recover_req,
  output logic [LW-1:0]          recover_lane,
  input  logic                   recover_ack,
  output logic [15:0]            fault_count
);

  // ---------------------------------------------------------------------------
  // Vote
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] enabled;
  logic [4:0]       n_enabled;
  logic [4:0]       agree;
  logic             found;
  logic [WIDTH-1:0] win_word;
  logic [LANES-1:0] err_vec;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold the value.
  always_comb begin
    enabled   = ~lane_failed;
    n_enabled = '0;
    agree     = '0;
    found     = 1'b0;
    win_word  = '0;
    err_vec   = '0;

    for (int i = 0; i < LANES; i++) begin
      if (enabled[i]) n_enabled = n_enabled + 5'd1;
    end

    // Scan from the top lane down so the lowest qualifying lane is the last
    // one written and therefore the winner.
    for (int i = LANES - 1; i >= 0; i--) begin
      agree = '0;
      for (int j = 0; j < LANES; j++) begin
        if (enabled[j] && (lane_data[j*WIDTH +: WIDTH] == lane_data[i*WIDTH +: WIDTH]))
          agree = agree + 5'd1;
      end
      if (enabled[i] && ((agree << 1) > n_enabled)) begin
        found    = 1'b1;
        win_word = lane_data[i*WIDTH +: WIDTH];
      end
    end

    for (int i = 0; i < LANES; i++) begin
      err_vec[i] = found && enabled[i] && (lane_data[i*WIDTH +: WIDTH] != win_word);
    end
  end

  // ---------------------------------------------------------------------------
  // Mismatch counters and failure detection
  // ---------------------------------------------------------------------------
  logic [3:0]       mis_cnt  [LANES];
  logic [3:0]       cnt_next [LANES];
  logic [LANES-1:0] fail_set;
  logic [LANES-1:0] ack_clear;
  logic [LANES-1:0] failed_next;

  always_comb begin
    fail_set = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_next[i] = mis_cnt[i];
      if (valid_in && found && enabled[i]) begin
        if (err_vec[i]) begin
          cnt_next[i] = (mis_cnt[i] == 4'hF) ? 4'hF : mis_cnt[i] + 4'd1;
          fail_set[i] = (cnt_next[i] >= 4'(THRESH));
        end else begin
          cnt_next[i] = '0;
        end
      end
      // A completed recovery restarts the lane's history, overriding any
      // same-edge update.
      if (ack_clear[i]) cnt_next[i] = '0;
    end

    // Never mask out every lane; the voter must always have a candidate.
    if (&(lane_failed | fail_set)) fail_set = '0;

    failed_next = (lane_failed | fail_set) & ~ack_clear;
  end

  // ---------------------------------------------------------------------------
  // Vote outputs, counters, failed mask, fault counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      voted_data  <= '0;
      voted_valid <= 1'b0;
      no_majority <= 1'b0;
      lane_err    <= '0;
      lane_failed <= '0;
      fault_count <= '0;
      // NOTE: the counter array is reset explicitly; it is a handful of
      // flops, not a RAM, and a stale count would fail a healthy lane early.
      for (int i = 0; i < LANES; i++) mis_cnt[i] <= '0;
    end else begin
      lane_failed <= failed_next;
      for (int i = 0; i < LANES; i++) mis_cnt[i] <= cnt_next[i];

      if (!valid_in) begin
        voted_valid <= 1'b0;
        no_majority <= 1'b0;
        lane_err    <= '0;
      end else if (found) begin
        voted_data  <= win_word;
        voted_valid <= 1'b1;
        no_majority <= 1'b0;
        lane_err    <= err_vec;
        if ((|err_vec) && (fault_count != 16'hFFFF))
          fault_count <= fault_count + 16'd1;
      end else begin
        voted_valid <= 1'b0;
        no_majority <= 1'b1;
        lane_err    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Recovery handshake
  // ---------------------------------------------------------------------------
`ifdef NMR_AUTO_RECOVER_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]    state;
  logic [LW-1:0] lowest_failed;

  always_comb begin
    lowest_failed = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_failed[i]) lowest_failed = LW'(i);
    end
  end

  always_comb begin
    ack_clear = '0;
    for (int i = 0; i < LANES; i++) begin
      ack_clear[i] = (state == ST_REQ) && recover_ack && (recover_lane == LW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      recover_req  <= 1'b0;
      recover_lane <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Acks arriving here are ignored; only the registered mask matters.
          if (|lane_failed) begin
            recover_lane <= lowest_failed;
            recover_req  <= 1'b1;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (recover_ack) begin
            recover_req <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          recover_req <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end
`else
  logic unused_recover_ack;

  assign unused_recover_ack = recover_ack;
  assign ack_clear          = '0;
  assign recover_req        = 1'b0;
  assign recover_lane       = '0;
`endif

endmodule
